// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types, default widths and the saturating-add helper
// used by the product accumulator.
//   state_t          : burst FSM states (IDLE, ACCUM, HOLD)
//   DEF_*_WIDTH      : default widths for the accumulator datapath
//   sat_sum/sat_ovf  : width-generic saturating add; operands are passed
//                      zero-extended to SAT_MAX_W bits, width selects the limit
package prod_accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   localparam int unsigned DEF_PROD_WIDTH = 9;
   localparam int unsigned DEF_ACC_WIDTH  = 16;
   localparam int unsigned DEF_CNT_WIDTH  = 4;

   // Widest accumulator the helpers support (width must be < SAT_MAX_W + 1).
   localparam int unsigned SAT_MAX_W = 32;

   // Saturated value of acc + addend, clipped to 2^width - 1.
   function automatic logic [SAT_MAX_W-1:0] sat_sum(
      input logic [SAT_MAX_W-1:0] acc,
      input logic [SAT_MAX_W-1:0] addend,
      input int unsigned          width
   );
      logic [SAT_MAX_W:0] total;
      logic [SAT_MAX_W:0] limit;
      total = {1'b0, acc} + {1'b0, addend};
      limit = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
      return SAT_MAX_W'((total > limit) ? limit : total);
   endfunction

   // Set when acc + addend does not fit in width bits.
   function automatic logic sat_ovf(
      input logic [SAT_MAX_W-1:0] acc,
      input logic [SAT_MAX_W-1:0] addend,
      input int unsigned          width
   );
      logic [SAT_MAX_W:0] total;
      logic [SAT_MAX_W:0] limit;
      total = {1'b0, acc} + {1'b0, addend};
      limit = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
      return (total > limit);
   endfunction

endpackage

// File: rtl/prod_accum_sat_adder.sv
// sat_adder: combinational saturating adder, ACC_WIDTH accumulator plus a
// zero-extended PROD_WIDTH addend.
//   acc    in  ACC_WIDTH   current accumulator value
//   addend in  PROD_WIDTH  unsigned product to add
//   sum    out ACC_WIDTH   saturated sum (all ones on overflow)
//   ovf    out 1           sum exceeded 2^ACC_WIDTH - 1
module sat_adder
   import prod_accum_pkg::*;
#(
   parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH
) (
   input  logic [ACC_WIDTH-1:0]  acc,
   input  logic [PROD_WIDTH-1:0] addend,
   output logic [ACC_WIDTH-1:0]  sum,
   output logic                  ovf
);

   always_comb begin
      sum = ACC_WIDTH'(sat_sum(SAT_MAX_W'(acc), SAT_MAX_W'(addend), ACC_WIDTH));
      ovf = sat_ovf(SAT_MAX_W'(acc), SAT_MAX_W'(addend), ACC_WIDTH);
   end

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums a programmed number of multiplier products into a
// saturating accumulator and presents the total over a valid/ready handshake.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start, len   burst request (sampled in IDLE) and product count
//   prod_valid, prod, prod_ready   product input handshake
//   acc_valid, acc_ready, acc_out, acc_ovf   result output handshake
//   busy         high whenever the FSM is not IDLE
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int unsigned INPUT1_WIDTH = 4,
   parameter int unsigned INPUT2_WIDTH = 5,
   parameter int unsigned PROD_WIDTH   = INPUT1_WIDTH + INPUT2_WIDTH,
   parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
   parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  len,
   input  logic                  prod_valid,
   input  logic [PROD_WIDTH-1:0] prod,
   output logic                  prod_ready,
   output logic                  acc_valid,
   input  logic                  acc_ready,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  acc_ovf,
   output logic                  busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 state;
   state_t                 state_next;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   len_q;
   logic                   accept;
   logic                   last;
   logic [ACC_WIDTH-1:0]   sum;
   logic                   sum_ovf;

   sat_adder #(
      .ACC_WIDTH  (ACC_WIDTH),
      .PROD_WIDTH (PROD_WIDTH)
   ) u_sat_adder (
      .acc    (acc_out),
      .addend (prod),
      .sum    (sum),
      .ovf    (sum_ovf)
   );

   // len_q is never zero in ACCUM, so len_q - 1 does not wrap there.
   assign last = (cnt == len_q - CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      prod_ready = 1'b0;
      accept     = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (len == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            prod_ready = 1'b1;
            accept     = prod_valid;
            if (prod_valid && last) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (acc_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The accumulator register doubles as acc_out, so the result stays
   // visible after the handshake until the next start clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out   <= '0;
         acc_ovf   <= 1'b0;
         acc_valid <= 1'b0;
         cnt       <= '0;
         len_q     <= '0;
      end else begin
         if (state == IDLE && start) begin
            acc_out <= '0;
            acc_ovf <= 1'b0;
            cnt     <= '0;
            len_q   <= len;
         end else if (accept) begin
            acc_out <= sum;
            acc_ovf <= acc_ovf | sum_ovf;
            cnt     <= cnt + CNT_ONE;
         end
         acc_valid <= (state_next == HOLD);
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        prod_valid;
   logic [8:0]  prod;
   logic        acc_ready;

   logic        pr16, av16, ov16, busy16;
   logic [15:0] ao16;
   logic        pr10, av10, ov10, busy10;
   logic [9:0]  ao10;

   int total;
   int bad;

   prod_accum u_dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_ready (pr16),
      .acc_valid  (av16),
      .acc_ready  (acc_ready),
      .acc_out    (ao16),
      .acc_ovf    (ov16),
      .busy       (busy16)
   );

   prod_accum #(.ACC_WIDTH(10)) u_dut10 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_ready (pr10),
      .acc_valid  (av10),
      .acc_ready  (acc_ready),
      .acc_out    (ao10),
      .acc_ovf    (ov10),
      .busy       (busy10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string          name;
      logic [3:0]     len;
      logic [3:0][8:0] p;
      logic [15:0]    exp16;
      logic           ovf16;
      logic [9:0]     exp10;
      logic           ovf10;
   } vec_t;

   vec_t vecs[7];

   function automatic vec_t mk(input string name, input logic [3:0] l,
                               input logic [8:0] p0, input logic [8:0] p1,
                               input logic [8:0] p2, input logic [8:0] p3,
                               input logic [15:0] e16, input logic o16,
                               input logic [9:0] e10, input logic o10);
      vec_t v;
      v.name  = name;
      v.len   = l;
      v.p[0]  = p0;
      v.p[1]  = p1;
      v.p[2]  = p2;
      v.p[3]  = p3;
      v.exp16 = e16;
      v.ovf16 = o16;
      v.exp10 = e10;
      v.ovf10 = o10;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      start = 1'b1;
      len   = v.len;
      tick();
      start = 1'b0;
      chk({v.name, " busy"}, busy16, 1);
      if (v.len != 0) begin
         chk({v.name, " prod_ready"}, pr16, 1);
         for (int i = 0; i < int'(v.len); i++) begin
            prod_valid = 1'b1;
            prod       = v.p[i % 4];
            tick();
         end
         prod_valid = 1'b0;
      end else begin
         chk({v.name, " prod_ready len0"}, pr16, 0);
      end
      chk({v.name, " acc_valid16"}, av16, 1);
      chk({v.name, " acc_out16"}, ao16, v.exp16);
      chk({v.name, " acc_ovf16"}, ov16, v.ovf16);
      chk({v.name, " acc_valid10"}, av10, 1);
      chk({v.name, " acc_out10"}, ao10, v.exp10);
      chk({v.name, " acc_ovf10"}, ov10, v.ovf10);
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      chk({v.name, " valid drop"}, av16, 0);
      chk({v.name, " idle"}, busy16, 0);
      chk({v.name, " out retained"}, ao16, v.exp16);
      tick();
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      len        = '0;
      prod_valid = 1'b0;
      prod       = '0;
      acc_ready  = 1'b0;

      vecs[0] = mk("basic465x3", 4'd3, 9'd465, 9'd465, 9'd465, 9'd465, 16'd1395, 1'b0, 10'd1023, 1'b1);
      vecs[1] = mk("after_sat",  4'd1, 9'd5,   9'd0,   9'd0,   9'd0,   16'd5,    1'b0, 10'd5,    1'b0);
      vecs[2] = mk("len0",       4'd0, 9'd0,   9'd0,   9'd0,   9'd0,   16'd0,    1'b0, 10'd0,    1'b0);
      vecs[3] = mk("small4",     4'd4, 9'd1,   9'd2,   9'd3,   9'd4,   16'd10,   1'b0, 10'd10,   1'b0);
      vecs[4] = mk("max15",      4'd15, 9'd511, 9'd511, 9'd511, 9'd511, 16'd7665, 1'b0, 10'd1023, 1'b1);
      vecs[5] = mk("pair475",    4'd2, 9'd465, 9'd10,  9'd0,   9'd0,   16'd475,  1'b0, 10'd475,  1'b0);
      vecs[6] = mk("wrap5",      4'd5, 9'd100, 9'd200, 9'd300, 9'd400, 16'd1100, 1'b0, 10'd1023, 1'b1);

      tick();
      tick();
      chk("reset acc_valid", av16, 0);
      chk("reset acc_out", ao16, 0);
      chk("reset acc_ovf", ov16, 0);
      chk("reset busy", busy16, 0);
      chk("reset prod_ready", pr16, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < 7; k++) begin
         run_vec(vecs[k]);
      end

      // Reset in the middle of a burst after two of four products
      start = 1'b1;
      len   = 4'd4;
      tick();
      start      = 1'b0;
      prod_valid = 1'b1;
      prod       = 9'd465;
      tick();
      tick();
      chk("midburst partial", ao16, 930);
      rst_n      = 1'b0;
      prod_valid = 1'b0;
      #2;
      chk("midrst acc_out", ao16, 0);
      chk("midrst acc_valid", av16, 0);
      chk("midrst acc_ovf", ov16, 0);
      chk("midrst busy", busy16, 0);
      chk("midrst prod_ready", pr16, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_vec(mk("post_reset", 4'd1, 9'd7, 9'd0, 9'd0, 9'd0, 16'd7, 1'b0, 10'd7, 1'b0));

      // Products offered in IDLE are not consumed
      prod_valid = 1'b1;
      prod       = 9'd99;
      tick();
      tick();
      chk("idle prod_ready", pr16, 0);
      chk("idle busy", busy16, 0);
      prod_valid = 1'b0;
      run_vec(mk("after_idle_offer", 4'd1, 9'd3, 9'd0, 9'd0, 9'd0, 16'd3, 1'b0, 10'd3, 1'b0));

      // Gaps on the product side and backpressure on the result side
      start = 1'b1;
      len   = 4'd2;
      tick();
      start      = 1'b0;
      prod_valid = 1'b1;
      prod       = 9'd465;
      tick();
      prod_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("gap prod_ready", pr16, 1);
         chk("gap acc_valid", av16, 0);
         chk("gap acc_out", ao16, 465);
      end
      prod_valid = 1'b1;
      prod       = 9'd10;
      tick();
      prod_valid = 1'b0;
      chk("gap result valid", av16, 1);
      chk("gap result", ao16, 475);
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("bp acc_valid", av16, 1);
         chk("bp acc_out", ao16, 475);
         chk("bp acc_ovf", ov16, 0);
         chk("bp prod_ready", pr16, 0);
      end
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      chk("bp release valid", av16, 0);
      chk("bp release busy", busy16, 0);
      chk("bp release out", ao16, 475);
      tick();

      // start pulses during ACCUM and on the HOLD handshake are ignored
      start = 1'b1;
      len   = 4'd3;
      tick();
      start      = 1'b0;
      prod_valid = 1'b1;
      prod       = 9'd1;
      tick();
      prod  = 9'd2;
      start = 1'b1;
      len   = 4'd1;
      tick();
      start = 1'b0;
      chk("ign mid acc_valid", av16, 0);
      prod = 9'd3;
      tick();
      prod_valid = 1'b0;
      chk("ign result valid", av16, 1);
      chk("ign result", ao16, 6);
      start     = 1'b1;
      len       = 4'd2;
      acc_ready = 1'b1;
      tick();
      start     = 1'b0;
      acc_ready = 1'b0;
      chk("ign hs busy", busy16, 0);
      chk("ign hs valid", av16, 0);
      chk("ign hs out", ao16, 6);
      tick();
      chk("ign stays idle", busy16, 0);
      chk("ign no ready", pr16, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
